// File: rtl/ahb_bridge_arbiter_pkg.sv
// rtl/ahb_bridge_arbiter_pkg.sv - shared types and constants for the AHB bridge arbiter
// Contents: arb_state_t FSM encoding, AHB HTRANS/HRESP codes,
//           default bridge address window and a window-check helper.
package bridge_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      BUSY = 2'd3
   } arb_state_t;

   localparam logic [1:0]  HTRANS_IDLE    = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ  = 2'b10;
   localparam logic [1:0]  HRESP_OKAY     = 2'b00;

   localparam logic [31:0] BRIDGE_ADDR_LO = 32'h8000_0000;
   localparam logic [31:0] BRIDGE_ADDR_HI = 32'h8C00_0000;

   // Window is [lo, hi): lo itself is valid, hi is the first invalid address.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (addr >= lo) && (addr < hi);
   endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_rr.sv
// rtl/ahb_bridge_arbiter_rr.sv - combinational round-robin pick for the bridge arbiter
// Ports:
//   req   in  N    request lines
//   ptr   in  IW   index of the previous winner
//   grant out N    one-hot winner (all zero when no request)
//   index out IW   binary index of the winner
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index
);

   // Requester index k steps after the previous winner, with wrap.
   function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int k);
      return IW'((int'(p) + k) % N);
   endfunction

   // Walk from the farthest slot to the nearest one; the last hit wins,
   // which gives the nearest requester after ptr the highest priority.
   always_comb begin
      grant = '0;
      index = '0;
      for (int k = N; k >= 1; k--) begin
         if (req[slot(ptr, k)]) begin
            grant = N'(1) << slot(ptr, k);
            index = slot(ptr, k);
         end
      end
   end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// rtl/ahb_bridge_arbiter.sv - shares the AHB-to-APB bridge slave port among N_REQ requesters
// Ports:
//   Hclk, Hreset                  clock, asynchronous active-high reset
//   req/req_write/req_addr/req_wdata  per-requester request, packed 32 bits per requester
//   gnt/done/err                  one-hot per-requester grant, completion and error pulses
//   rdata                         read data, valid in the done cycle of a read
//   Haddr/Hwdata/Hwrite/Htrans/Hreadyin  bridge AHB master outputs
//   Hreadyout/Hrdata/Hresp        bridge AHB slave responses
module ahb_bridge_arbiter
   import bridge_arb_pkg::*;
#(
   parameter int          N_REQ   = 2,
   parameter int          TIMEOUT = 64,
   parameter logic [31:0] ADDR_LO = BRIDGE_ADDR_LO,
   parameter logic [31:0] ADDR_HI = BRIDGE_ADDR_HI
) (
   input  logic                Hclk,
   input  logic                Hreset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    req_write,
   input  logic [N_REQ*32-1:0] req_addr,
   input  logic [N_REQ*32-1:0] req_wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic [N_REQ-1:0]    err,
   output logic [31:0]         rdata,
   output logic [31:0]         Haddr,
   output logic [31:0]         Hwdata,
   output logic                Hwrite,
   output logic [1:0]          Htrans,
   output logic                Hreadyin,
   input  logic                Hreadyout,
   input  logic [31:0]         Hrdata,
   input  logic [1:0]          Hresp
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;        // previous winner; also the owner of the live transfer
   logic [CNT_W-1:0] count;
   logic [31:0]      lat_wdata;
   logic             lat_write;

   logic [N_REQ-1:0] cand_req;
   logic [N_REQ-1:0] win_grant;
   logic [IDX_W-1:0] win_idx;
   logic [31:0]      win_addr;
   logic             win_ok;
   logic [N_REQ-1:0] owner;

   // A requester still sees its own done/err in this cycle and may not
   // have dropped req yet; hide it so the finished request is not re-served.
   assign cand_req = req & ~(done | err);

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IDX_W)
   ) u_rr (
      .req   (cand_req),
      .ptr   (ptr),
      .grant (win_grant),
      .index (win_idx)
   );

   assign win_addr = req_addr[32*int'(win_idx) +: 32];
   assign win_ok   = in_window(win_addr, ADDR_LO, ADDR_HI);
   assign owner    = N_REQ'(1) << ptr;

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state     <= IDLE;
         ptr       <= IDX_W'(N_REQ - 1);
         count     <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
         gnt       <= '0;
         done      <= '0;
         err       <= '0;
         rdata     <= '0;
         Haddr     <= '0;
         Hwdata    <= '0;
         Hwrite    <= 1'b0;
         Htrans    <= HTRANS_IDLE;
         Hreadyin  <= 1'b0;
      end else begin
         Hreadyin <= 1'b1;
         gnt      <= '0;
         done     <= '0;
         err      <= '0;

         case (state)
            IDLE: begin
               if (|cand_req) begin
                  ptr       <= win_idx;
                  lat_wdata <= req_wdata[32*int'(win_idx) +: 32];
                  lat_write <= req_write[win_idx];
                  if (win_ok) begin
                     state  <= ADDR;
                     gnt    <= win_grant;
                     Htrans <= HTRANS_NONSEQ;
                     Haddr  <= win_addr;
                     Hwrite <= req_write[win_idx];
                  end else begin
                     // Out-of-window: reject without touching the bus.
                     err <= win_grant;
                  end
               end
            end

            ADDR: begin
               Htrans <= HTRANS_IDLE;
               Hwdata <= lat_wdata;
               count  <= '0;
               state  <= DATA;
            end

            // Bridge may keep Hreadyout high for a cycle before stalling.
            DATA: begin
               if (count == COUNT_LAST) begin
                  err    <= owner;
                  Htrans <= HTRANS_IDLE;
                  state  <= IDLE;
               end else begin
                  count <= count + 1'b1;
                  if (!Hreadyout) begin
                     state <= BUSY;
                  end
               end
            end

            // A real response in the last allowed cycle beats the timeout.
            BUSY: begin
               if (Hreadyout) begin
                  if (!lat_write) begin
                     rdata <= Hrdata;
                  end
                  if (Hresp == HRESP_OKAY) begin
                     done <= owner;
                  end else begin
                     err <= owner;
                  end
                  state <= IDLE;
               end else if (count == COUNT_LAST) begin
                  err    <= owner;
                  Htrans <= HTRANS_IDLE;
                  state  <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
